// File: rtl/regfile_pkg.sv
// Shared widths, index constants and types for the register file / write-back scoreboard.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int PEND_W   = 2;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PEND_W-1:0] pend_t;

    localparam addr_t REG_ZERO = '0;
    localparam pend_t PEND_MAX = pend_t'((1 << PEND_W) - 1);
    localparam pend_t PEND_ONE = pend_t'(1);

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down count of in-flight writes to one architectural register.
module pend_counter
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  dec,
    output pend_t count,
    output logic  isZero,
    output logic  isMax
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && count != PEND_MAX) begin
            count <= count + PEND_ONE;
        end else if (dec && !inc && count != '0) begin
            count <= count - PEND_ONE;
        end
    end

    assign isZero = (count == '0);
    assign isMax  = (count == PEND_MAX);

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 architectural register file with write-back commit and RAW scoreboard.
// Define REGFILE_BYPASS_EN for write-through reads and same-cycle busy release.
module reg_file_wb
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              regWriteIn,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readAddr1,
    input  logic [ADDR_W-1:0] readAddr2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              issueValid,
    input  logic              issueWrites,
    input  logic [ADDR_W-1:0] issueDest,
    output logic              issueAccept,
    output logic              stall,
    output logic              retireErr
);

    data_t regs [NUM_REGS];

    logic [NUM_REGS-1:0][PEND_W-1:0] pend;
    logic [NUM_REGS-1:0]             pend_zero;
    logic [NUM_REGS-1:0]             pend_max;
    logic [NUM_REGS-1:0]             inc_vec;
    logic [NUM_REGS-1:0]             dec_vec;

    logic wb_valid;
    logic busy1;
    logic busy2;
    logic full;

    // Writes to r0 are architecturally discarded and never touch the scoreboard.
    assign wb_valid = regWriteIn && (writeAddr != REG_ZERO);

    // ---------------------------------------------------------------------
    // Register storage
    // ---------------------------------------------------------------------
    // NOTE: the array is reset because software relies on every register reading 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[writeAddr] <= writeData;
        end
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        readData1 = (readAddr1 == REG_ZERO) ? '0 : regs[readAddr1];
        readData2 = (readAddr2 == REG_ZERO) ? '0 : regs[readAddr2];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && writeAddr == readAddr1) readData1 = writeData;
        if (wb_valid && writeAddr == readAddr2) readData2 = writeData;
`endif
    end

    // ---------------------------------------------------------------------
    // Pending-write scoreboard, one counter per writable register
    // ---------------------------------------------------------------------
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        if (r == 0) begin : g_zero
            assign pend[r]      = '0;
            assign pend_zero[r] = 1'b1;
            assign pend_max[r]  = 1'b0;
            assign inc_vec[r]   = 1'b0;
            assign dec_vec[r]   = 1'b0;
        end else begin : g_cnt
            assign inc_vec[r] = issueAccept && issueWrites && (issueDest == ADDR_W'(r));
            assign dec_vec[r] = regWriteIn && (writeAddr == ADDR_W'(r)) && !pend_zero[r];

            pend_counter u_pend (
                .clk    (clk),
                .rst    (rst),
                .inc    (inc_vec[r]),
                .dec    (dec_vec[r]),
                .count  (pend[r]),
                .isZero (pend_zero[r]),
                .isMax  (pend_max[r])
            );
        end
    end

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    always_comb begin
        busy1 = (pend[readAddr1] != '0);
        busy2 = (pend[readAddr2] != '0);
`ifdef REGFILE_BYPASS_EN
        // The last outstanding write is being forwarded this cycle, so the source is ready.
        if (dec_vec[readAddr1] && pend[readAddr1] == PEND_ONE) busy1 = 1'b0;
        if (dec_vec[readAddr2] && pend[readAddr2] == PEND_ONE) busy2 = 1'b0;
`endif
    end

    // A retire to the same register frees a slot, so a saturated counter can still accept.
    assign full = issueValid && issueWrites && (issueDest != REG_ZERO)
               && pend_max[issueDest] && !dec_vec[issueDest];

    assign stall       = issueValid && (busy1 || busy2 || full);
    assign issueAccept = issueValid && !stall;

    // ---------------------------------------------------------------------
    // Sticky error: write-back with nothing outstanding for that register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            retireErr <= 1'b0;
        end else if (wb_valid && pend_zero[writeAddr]) begin
            retireErr <= 1'b1;
        end
    end

endmodule
